// File: rtl/main_kernel_stream_ctrl.sv
// Run-length sequencer for one main_kernel_top lane: issues N lockstep input
// items, collects N lockstep output items, then pulses done. Only the
// handshakes pass through here; the data buses go around this block.
module main_kernel_stream_ctrl #(
    parameter int CNTW  = 32,
    parameter int NIN   = 4,
    parameter int NOUT  = 4,
    parameter int WDOGW = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic [CNTW-1:0] ntotal_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o,
    input  logic [NIN-1:0]  src_valid_i,
    output logic [NIN-1:0]  src_ready_o,
    output logic            k_ivalid_o,
    input  logic            k_iready_i,
    input  logic            k_ovalid_i,
    output logic            k_oready_o,
    input  logic [NOUT-1:0] snk_ready_i,
    output logic [NOUT-1:0] snk_valid_o,
    output logic [CNTW-1:0] issued_o,
    output logic [CNTW-1:0] collected_o
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CNTW-1:0]   ntot_q, ntot_d;
    logic [CNTW-1:0]   issued_q, issued_d;
    logic [CNTW-1:0]   coll_q, coll_d;
    logic [WDOGW-1:0]  wdog_q, wdog_d;
    logic              err_q, err_d;
    logic              accept, fire_in, fire_out, wdog_exp;

    // A start is only taken in IDLE, and a simultaneous abort cancels it.
    assign accept   = (state_q == S_IDLE) && start_i && !abort_i;
    assign fire_in  = k_ivalid_o && k_iready_i;
    assign fire_out = k_ovalid_i && k_oready_o;
    // Expiry fires on the stall cycle that would drive the counter to all-ones.
    assign wdog_exp = (state_q == S_DRAIN) && (&wdog_d);

    // State and counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            ntot_q   <= '0;
            issued_q <= '0;
            coll_q   <= '0;
            wdog_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ntot_q   <= ntot_d;
            issued_q <= issued_d;
            coll_q   <= coll_d;
            wdog_q   <= wdog_d;
            err_q    <= err_d;
        end
    end

    // Drain watchdog: counts consecutive no-output cycles, idle outside DRAIN.
    always_comb begin
        wdog_d = '0;
        if (state_q == S_DRAIN && !fire_out)
            wdog_d = wdog_q + WDOGW'(1);
    end

    // Item counters, latched length and sticky error.
    always_comb begin
        ntot_d   = ntot_q;
        issued_d = issued_q + CNTW'(fire_in);
        coll_d   = coll_q + CNTW'(fire_out);
        err_d    = err_q;
        if (accept) begin
            ntot_d   = ntotal_i;
            issued_d = '0;
            coll_d   = '0;
            err_d    = 1'b0;
        end
        if (wdog_exp && !abort_i)
            err_d = 1'b1;
    end

    // Next-state logic; abort overrides every transition out of a busy state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept)
                    state_d = (ntotal_i != '0) ? S_RUN : S_DONE;
            end
            S_RUN: begin
                // issued_q is registered, so DRAIN follows one cycle after the last issue.
                if (issued_q == ntot_q)
                    state_d = (coll_d == ntot_q) ? S_DONE : S_DRAIN;
            end
            S_DRAIN: begin
                if (coll_d == ntot_q || wdog_exp)
                    state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort_i && state_q != S_IDLE)
            state_d = S_IDLE;
    end

    // Handshake gating and status outputs.
    always_comb begin
        busy_o      = (state_q == S_RUN) || (state_q == S_DRAIN);
        done_o      = (state_q == S_DONE);
        err_o       = err_q;
        k_ivalid_o  = (state_q == S_RUN) && (issued_q < ntot_q) && (&src_valid_i);
        k_oready_o  = busy_o && (coll_q < ntot_q) && (&snk_ready_i);
        src_ready_o = {NIN{fire_in}};
        snk_valid_o = {NOUT{fire_out}};
        issued_o    = issued_q;
        collected_o = coll_q;
    end

endmodule
